// File: rtl/rename_regfile_if.sv
// Rename/register-file bus: dispatch lookups, ROB queries, CDB broadcast, commit and flush.
interface rename_regfile_if #(
  parameter int ROB_ADDR_WIDTH = 4,
  parameter int XLEN           = 32
);
  logic                      dispatch_valid;
  logic [4:0]                dispatch_rs1;
  logic [4:0]                dispatch_rs2;
  logic [4:0]                dispatch_rd;
  logic                      dispatch_rd_valid;
  logic [ROB_ADDR_WIDTH-1:0] dispatch_rob_tag;

  logic [XLEN-1:0]           rs1_value;
  logic [XLEN-1:0]           rs2_value;
  logic                      rs1_ready;
  logic                      rs2_ready;
  logic [ROB_ADDR_WIDTH-1:0] rs1_tag;
  logic [ROB_ADDR_WIDTH-1:0] rs2_tag;

  logic [ROB_ADDR_WIDTH-1:0] rob_q1_tag;
  logic [ROB_ADDR_WIDTH-1:0] rob_q2_tag;
  logic                      rob_q1_ready;
  logic                      rob_q2_ready;
  logic [XLEN-1:0]           rob_q1_value;
  logic [XLEN-1:0]           rob_q2_value;

  logic                      cdb_valid;
  logic [ROB_ADDR_WIDTH-1:0] cdb_tag;
  logic [XLEN-1:0]           cdb_data;

  logic                      commit_valid;
  logic [4:0]                commit_dest_reg;
  logic [XLEN-1:0]           commit_value;
  logic                      commit_reg_write;
  logic [ROB_ADDR_WIDTH-1:0] commit_rob_tag;

  logic                      flush;

  modport master (
    output dispatch_valid, dispatch_rs1, dispatch_rs2, dispatch_rd, dispatch_rd_valid,
           dispatch_rob_tag, rob_q1_ready, rob_q2_ready, rob_q1_value, rob_q2_value,
           cdb_valid, cdb_tag, cdb_data, commit_valid, commit_dest_reg, commit_value,
           commit_reg_write, commit_rob_tag, flush,
    input  rs1_value, rs2_value, rs1_ready, rs2_ready, rs1_tag, rs2_tag,
           rob_q1_tag, rob_q2_tag
  );

  modport slave (
    input  dispatch_valid, dispatch_rs1, dispatch_rs2, dispatch_rd, dispatch_rd_valid,
           dispatch_rob_tag, rob_q1_ready, rob_q2_ready, rob_q1_value, rob_q2_value,
           cdb_valid, cdb_tag, cdb_data, commit_valid, commit_dest_reg, commit_value,
           commit_reg_write, commit_rob_tag, flush,
    output rs1_value, rs2_value, rs1_ready, rs2_ready, rs1_tag, rs2_tag,
           rob_q1_tag, rob_q2_tag
  );
endinterface

// File: rtl/rename_regfile.sv
// Architectural register file plus rename alias table with combinational operand lookup.
// Define RENAME_CDB_BYPASS_EN to let a matching CDB broadcast resolve operands in the same cycle.
module rename_regfile #(
  parameter int ROB_ADDR_WIDTH = 4,
  parameter int XLEN           = 32
) (
  input logic             clock,
  input logic             reset,
  rename_regfile_if.slave bus
);

  logic [XLEN-1:0]           arf     [32];
  logic [31:0]               busy;
  logic [ROB_ADDR_WIDTH-1:0] rat_tag [32];

  logic commit_write;
  logic commit_clear;
  logic rename_en;

  // Returns {ready, value}; all sources observe pre-edge state only.
  function automatic logic [XLEN:0] resolve(input logic [4:0]      rs,
                                            input logic            q_ready,
                                            input logic [XLEN-1:0] q_value);
    logic            ready;
    logic [XLEN-1:0] value;
    ready = 1'b0;
    value = '0;
    if (rs == 5'd0) begin
      ready = 1'b1;
    end else if (!busy[rs]) begin
      ready = 1'b1;
      value = arf[rs];
    end else if (bus.commit_valid && (bus.commit_rob_tag == rat_tag[rs])) begin
      ready = 1'b1;
      value = bus.commit_value;
    end else if (q_ready) begin
      ready = 1'b1;
      value = q_value;
    end
`ifdef RENAME_CDB_BYPASS_EN
    else if (bus.cdb_valid && (bus.cdb_tag == rat_tag[rs])) begin
      ready = 1'b1;
      value = bus.cdb_data;
    end
`endif
    return {ready, value};
  endfunction

  always_comb begin
    {bus.rs1_ready, bus.rs1_value} = resolve(bus.dispatch_rs1, bus.rob_q1_ready, bus.rob_q1_value);
    {bus.rs2_ready, bus.rs2_value} = resolve(bus.dispatch_rs2, bus.rob_q2_ready, bus.rob_q2_value);
  end

  assign bus.rs1_tag    = rat_tag[bus.dispatch_rs1];
  assign bus.rs2_tag    = rat_tag[bus.dispatch_rs2];
  assign bus.rob_q1_tag = rat_tag[bus.dispatch_rs1];
  assign bus.rob_q2_tag = rat_tag[bus.dispatch_rs2];

`ifndef RENAME_CDB_BYPASS_EN
  logic unused_cdb;
  assign unused_cdb = ^{bus.cdb_valid, bus.cdb_tag, bus.cdb_data};
`endif

  always_comb begin
    commit_write = bus.commit_valid && bus.commit_reg_write && (bus.commit_dest_reg != 5'd0);
    commit_clear = bus.commit_valid && (bus.commit_dest_reg != 5'd0) &&
                   busy[bus.commit_dest_reg] &&
                   (rat_tag[bus.commit_dest_reg] == bus.commit_rob_tag);
    rename_en    = bus.dispatch_valid && bus.dispatch_rd_valid &&
                   (bus.dispatch_rd != 5'd0) && !bus.flush;
  end

  // Rename is assigned after the commit clear so it wins on the same register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 32; i++) begin
        arf[i[4:0]]     <= '0;
        rat_tag[i[4:0]] <= '0;
      end
      busy <= '0;
    end else begin
      if (commit_write) arf[bus.commit_dest_reg] <= bus.commit_value;
      if (bus.flush) begin
        busy <= '0;
      end else begin
        if (commit_clear) busy[bus.commit_dest_reg] <= 1'b0;
        if (rename_en) begin
          busy[bus.dispatch_rd]    <= 1'b1;
          rat_tag[bus.dispatch_rd] <= bus.dispatch_rob_tag;
        end
      end
    end
  end

endmodule

// File: tb/tb_rename_regfile.sv
// Directed bench for rename_regfile: register-level model checked every cycle plus literal checks.
module tb_rename_regfile;
  localparam int RW = 4;
  localparam int XL = 32;

  logic clock;
  logic reset;

  rename_regfile_if #(.ROB_ADDR_WIDTH(RW), .XLEN(XL)) rif ();

  rename_regfile #(.ROB_ADDR_WIDTH(RW), .XLEN(XL)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (rif)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: what each architectural register currently holds and who will produce it.
  logic [31:0] m_arf  [32];
  bit          m_busy [32];
  int          m_tag  [32];

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        m_arf[i] = 0; m_busy[i] = 0; m_tag[i] = 0;
      end
    end else begin
      int cd, rd;
      bit clear_it;
      cd = int'(rif.commit_dest_reg);
      rd = int'(rif.dispatch_rd);
      clear_it = rif.commit_valid && m_busy[cd] && (m_tag[cd] == int'(rif.commit_rob_tag));
      if (rif.commit_valid && rif.commit_reg_write && cd != 0) m_arf[cd] = rif.commit_value;
      if (clear_it) m_busy[cd] = 0;
      if (rif.dispatch_valid && rif.dispatch_rd_valid && rd != 0 && !rif.flush) begin
        m_busy[rd] = 1;
        m_tag[rd]  = int'(rif.dispatch_rob_tag);
      end
      if (rif.flush)
        for (int i = 0; i < 32; i++) m_busy[i] = 0;
      m_busy[0] = 0;
    end
  end

  function automatic void model_lookup(input int rs, input bit qr, input logic [31:0] qv,
                                       output bit rdy, output logic [31:0] val);
    rdy = 0; val = 0;
    if (rs == 0) rdy = 1;
    else if (!m_busy[rs]) begin rdy = 1; val = m_arf[rs]; end
    else if (rif.commit_valid && int'(rif.commit_rob_tag) == m_tag[rs]) begin rdy = 1; val = rif.commit_value; end
    else if (qr) begin rdy = 1; val = qv; end
`ifdef RENAME_CDB_BYPASS_EN
    else if (rif.cdb_valid && int'(rif.cdb_tag) == m_tag[rs]) begin rdy = 1; val = rif.cdb_data; end
`endif
  endfunction

  always @(negedge clock) begin
    bit r1, r2;
    logic [31:0] v1, v2;
    int s1, s2;
    s1 = int'(rif.dispatch_rs1);
    s2 = int'(rif.dispatch_rs2);
    model_lookup(s1, rif.rob_q1_ready, rif.rob_q1_value, r1, v1);
    model_lookup(s2, rif.rob_q2_ready, rif.rob_q2_value, r2, v2);
    check("cyc_rs1_ready", 64'(rif.rs1_ready), 64'(r1));
    check("cyc_rs1_value", 64'(rif.rs1_value), 64'(v1));
    check("cyc_rs2_ready", 64'(rif.rs2_ready), 64'(r2));
    check("cyc_rs2_value", 64'(rif.rs2_value), 64'(v2));
    check("cyc_rs1_tag",   64'(rif.rs1_tag),    64'(m_tag[s1]));
    check("cyc_rs2_tag",   64'(rif.rs2_tag),    64'(m_tag[s2]));
    check("cyc_q1_tag",    64'(rif.rob_q1_tag), 64'(m_tag[s1]));
    check("cyc_q2_tag",    64'(rif.rob_q2_tag), 64'(m_tag[s2]));
  end

  task automatic idle();
    rif.dispatch_valid = 0; rif.dispatch_rs1 = 0; rif.dispatch_rs2 = 0;
    rif.dispatch_rd = 0; rif.dispatch_rd_valid = 0; rif.dispatch_rob_tag = 0;
    rif.rob_q1_ready = 0; rif.rob_q2_ready = 0; rif.rob_q1_value = 0; rif.rob_q2_value = 0;
    rif.cdb_valid = 0; rif.cdb_tag = 0; rif.cdb_data = 0;
    rif.commit_valid = 0; rif.commit_dest_reg = 0; rif.commit_value = 0;
    rif.commit_reg_write = 0; rif.commit_rob_tag = 0; rif.flush = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic dispatch(input int rd, input int tag);
    rif.dispatch_valid = 1; rif.dispatch_rd_valid = 1;
    rif.dispatch_rd = 5'(rd); rif.dispatch_rob_tag = RW'(tag);
  endtask

  task automatic commit(input int rd, input int tag, input logic [31:0] val);
    rif.commit_valid = 1; rif.commit_reg_write = 1;
    rif.commit_dest_reg = 5'(rd); rif.commit_rob_tag = RW'(tag); rif.commit_value = val;
  endtask

  typedef struct {
    int rd; int tag; int rs1; int rs2; bit q1r; logic [31:0] q1v; int crd; int ctag; bit fl;
  } vec_t;

  vec_t vecs [8] = '{
    '{10, 4, 10, 11, 0, 32'h0,        0, 0,  0},
    '{11, 5, 10, 11, 1, 32'hA5A5_0001, 0, 0,  0},
    '{12, 6, 11, 12, 0, 32'h0,        10, 4, 0},
    '{10, 8, 10, 12, 0, 32'h0,        11, 5, 0},
    '{0,  3, 10, 0,  1, 32'h1111_2222, 12, 6, 0},
    '{13, 9, 13, 10, 0, 32'h0,        10, 4, 0},
    '{14, 2, 10, 13, 0, 32'h0,        10, 8, 1},
    '{15, 1, 13, 14, 0, 32'h0,        0, 0,  0}
  };

  initial begin
    reset = 1'b1;
    idle();
    rif.dispatch_rs1 = 5;
    #3;
    check("reset_rs1_ready", 64'(rif.rs1_ready), 64'd1);
    check("reset_rs1_value", 64'(rif.rs1_value), 64'd0);
    check("reset_rs2_ready", 64'(rif.rs2_ready), 64'd1);
    check("reset_rs2_value", 64'(rif.rs2_value), 64'd0);
    #19 reset = 1'b0;
    tick();

    // rd==rs1 in the same dispatch sees the old mapping
    dispatch(3, 7); rif.dispatch_rs1 = 3; #3;
    check("same_cyc_old_ready", 64'(rif.rs1_ready), 64'd1);
    check("same_cyc_old_value", 64'(rif.rs1_value), 64'd0);
    tick();
    rif.dispatch_rs1 = 3; #3;
    check("busy_rs1_ready", 64'(rif.rs1_ready), 64'd0);
    check("busy_rs1_tag",   64'(rif.rs1_tag),   64'd7);
    check("busy_q1_tag",    64'(rif.rob_q1_tag), 64'd7);
    check("busy_rs1_value", 64'(rif.rs1_value), 64'd0);
    tick();
    rif.dispatch_rs1 = 3; rif.rob_q1_ready = 1; rif.rob_q1_value = 32'h1234; #3;
    check("rob_fwd_value", 64'(rif.rs1_value), 64'h1234);
    tick();
    rif.dispatch_rs1 = 3; commit(3, 7, 32'hDEAD_BEEF); #3;
    check("commit_fwd_ready", 64'(rif.rs1_ready), 64'd1);
    check("commit_fwd_value", 64'(rif.rs1_value), 64'hDEAD_BEEF);
    tick();
    rif.dispatch_rs1 = 3; #3;
    check("post_commit_ready", 64'(rif.rs1_ready), 64'd1);
    check("post_commit_value", 64'(rif.rs1_value), 64'hDEAD_BEEF);
    tick();
    dispatch(3, 7);
    tick();
    dispatch(3, 9); commit(3, 7, 32'hCAFE_0001); rif.dispatch_rs2 = 3; #3;
    check("rename_commit_fwd", 64'(rif.rs2_value), 64'hCAFE_0001);
    tick();
    rif.dispatch_rs1 = 3; #3;
    check("rename_wins_ready", 64'(rif.rs1_ready), 64'd0);
    check("rename_wins_tag",   64'(rif.rs1_tag),   64'd9);
    tick();
    dispatch(4, 2); rif.flush = 1; commit(5, 0, 32'h77); rif.dispatch_rs1 = 3;
    tick();
    rif.dispatch_rs1 = 3; rif.dispatch_rs2 = 4; #3;
    check("flush_rs1_ready", 64'(rif.rs1_ready), 64'd1);
    check("flush_arf3",      64'(rif.rs1_value), 64'hCAFE_0001);
    check("flush_rs2_ready", 64'(rif.rs2_ready), 64'd1);
    tick();
    rif.dispatch_rs1 = 5; #3;
    check("flush_commit_arf5", 64'(rif.rs1_value), 64'h77);
    tick();
    dispatch(6, 1);
    tick();
    rif.dispatch_rs1 = 6; rif.cdb_valid = 1; rif.cdb_tag = 1; rif.cdb_data = 32'h55; #3;
`ifdef RENAME_CDB_BYPASS_EN
    check("cdb_bypass_ready", 64'(rif.rs1_ready), 64'd1);
    check("cdb_bypass_value", 64'(rif.rs1_value), 64'h55);
`else
    check("cdb_nobypass_ready", 64'(rif.rs1_ready), 64'd0);
    check("cdb_nobypass_value", 64'(rif.rs1_value), 64'd0);
`endif
    tick();
    commit(6, 3, 32'h99); rif.dispatch_rs1 = 6; #3;
    check("mismatch_commit_ready", 64'(rif.rs1_ready), 64'd0);
    tick();
    rif.dispatch_rs1 = 6; #3;
    check("mismatch_keeps_busy", 64'(rif.rs1_ready), 64'd0);
    check("mismatch_keeps_tag",  64'(rif.rs1_tag),   64'd1);
    tick();
    dispatch(0, 5);
    tick();
    rif.dispatch_rs1 = 0; rif.dispatch_rs2 = 6; #3;
    check("x0_ready", 64'(rif.rs1_ready), 64'd1);
    check("x0_value", 64'(rif.rs1_value), 64'd0);
    check("x0_tag",   64'(rif.rs1_tag),   64'd0);
    tick();

    foreach (vecs[k]) begin
      dispatch(vecs[k].rd, vecs[k].tag);
      rif.dispatch_rs1 = 5'(vecs[k].rs1); rif.dispatch_rs2 = 5'(vecs[k].rs2);
      rif.rob_q1_ready = vecs[k].q1r; rif.rob_q1_value = vecs[k].q1v;
      if (vecs[k].crd != 0) commit(vecs[k].crd, vecs[k].ctag, 32'h1000 + 32'(k));
      rif.flush = vecs[k].fl;
      tick();
    end
    rif.dispatch_rs1 = 10; rif.dispatch_rs2 = 15;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
